// File: rtl/regfile_mbist_pkg.sv
// Shared types and per-element March C- constants for the register-file MBIST controller.
// Used by regfile_mbist_ctrl (optional build macro: MBIST_STOP_ON_FAIL_EN).
package regfile_mbist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      M0 = 3'd0,
      M1 = 3'd1,
      M2 = 3'd2,
      M3 = 3'd3,
      M4 = 3'd4,
      M5 = 3'd5
   } elem_e;

   typedef enum logic {
      OP_RD,
      OP_WR
   } op_e;

   // One bit per march element, bit i belongs to element Mi.
   localparam logic [5:0] ELEM_DOWN   = 6'b011000;
   localparam logic [5:0] ELEM_HAS_RD = 6'b111110;
   localparam logic [5:0] ELEM_HAS_WR = 6'b011111;
   localparam logic [5:0] ELEM_RD_VAL = 6'b010100;
   localparam logic [5:0] ELEM_WR_VAL = 6'b001010;

   function automatic elem_e next_elem(elem_e e);
      return (e == M5) ? M5 : elem_e'(e + 3'd1);
   endfunction

endpackage

// File: rtl/regfile_mbist_addr_gen.sv
// Up/down address counter confined to ADDR_LO..2^ADDR_WIDTH-1; it saturates at the
// bound and raises last on the final address of the current direction.
module regfile_mbist_addr_gen #(
   parameter int ADDR_WIDTH = 5,
   parameter int ADDR_LO    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  down,
   input  logic                  step,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_HI  = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MIN = ADDR_WIDTH'(ADDR_LO);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   logic down_q;

   assign last = down_q ? (addr == ADDR_MIN) : (addr == ADDR_HI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         down_q <= 1'b0;
         addr   <= ADDR_MIN;
      end else if (load) begin
         down_q <= down;
         addr   <= down ? ADDR_HI : ADDR_MIN;
      end else if (step && !last) begin
         addr <= down_q ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
      end
   end

endmodule

// File: rtl/regfile_mbist_ctrl.sv
// March C- MBIST controller driving the register-file test wrapper's 1RW port.
// Build option MBIST_STOP_ON_FAIL_EN: abort to DONE on the first read mismatch.
module regfile_mbist_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_LO    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  fail_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o,
   output logic [2:0]            fail_elem_o,
   output logic                  bist_o,
   output logic                  csn_t_o,
   output logic                  wen_t_o,
   output logic [ADDR_WIDTH-1:0] a_t_o,
   output logic [DATA_WIDTH-1:0] d_t_o,
   input  logic [DATA_WIDTH-1:0] q_t_i
);

   import regfile_mbist_pkg::*;

   state_e                state_q, state_d;
   elem_e                 elem_q, elem_d;
   op_e                   op_q, op_d;
   logic                  last_issued_q, last_issued_d;
   elem_e                 port_elem_q, port_elem_d;
   logic                  csn_d, wen_d;
   logic [ADDR_WIDTH-1:0] a_d;
   logic [DATA_WIDTH-1:0] d_d;

   logic                  cmp_valid_q;
   logic [ADDR_WIDTH-1:0] cmp_addr_q;
   elem_e                 cmp_elem_q;

   logic                  ag_load, ag_down, ag_step, ag_last;
   logic [ADDR_WIDTH-1:0] ag_addr;
   logic                  accept, mismatch;

   regfile_mbist_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ADDR_LO    (ADDR_LO)
   ) u_addr_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ag_load),
      .down  (ag_down),
      .step  (ag_step),
      .addr  (ag_addr),
      .last  (ag_last)
   );

   assign accept   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   // The compare stage sees read data one cycle after the read left the port.
   assign mismatch = cmp_valid_q && ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                     (q_t_i != {DATA_WIDTH{ELEM_RD_VAL[cmp_elem_q]}});

   always_comb begin
      // NOTE: every signal of this block is defaulted first, so no branch can infer a latch.
      state_d       = state_q;
      elem_d        = elem_q;
      op_d          = op_q;
      last_issued_d = 1'b0;
      port_elem_d   = port_elem_q;
      csn_d         = 1'b1;
      wen_d         = 1'b1;
      a_d           = a_t_o;
      d_d           = d_t_o;
      ag_load       = 1'b0;
      ag_down       = 1'b0;
      ag_step       = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_d = ST_RUN;
               elem_d  = M0;
               op_d    = ELEM_HAS_RD[M0] ? OP_RD : OP_WR;
               ag_load = 1'b1;
               ag_down = ELEM_DOWN[M0];
            end
         end
         ST_RUN: begin
            if (last_issued_q) begin
               state_d = ST_DRAIN;
            end else begin
               csn_d       = 1'b0;
               wen_d       = (op_q != OP_WR);
               a_d         = ag_addr;
               d_d         = {DATA_WIDTH{ELEM_WR_VAL[elem_q]}};
               port_elem_d = elem_q;
               // Read-write elements write the address they just read before moving on.
               if (op_q == OP_RD && ELEM_HAS_WR[elem_q]) begin
                  op_d = OP_WR;
               end else if (!ag_last) begin
                  ag_step = 1'b1;
                  op_d    = ELEM_HAS_RD[elem_q] ? OP_RD : OP_WR;
               end else if (elem_q == M5) begin
                  last_issued_d = 1'b1;
               end else begin
                  elem_d  = next_elem(elem_q);
                  ag_load = 1'b1;
                  ag_down = ELEM_DOWN[next_elem(elem_q)];
                  op_d    = ELEM_HAS_RD[next_elem(elem_q)] ? OP_RD : OP_WR;
               end
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase

`ifdef MBIST_STOP_ON_FAIL_EN
      if (mismatch) begin
         state_d       = ST_DONE;
         csn_d         = 1'b1;
         wen_d         = 1'b1;
         ag_load       = 1'b0;
         ag_step       = 1'b0;
         last_issued_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         elem_q        <= M0;
         op_q          <= OP_WR;
         last_issued_q <= 1'b0;
         port_elem_q   <= M0;
         csn_t_o       <= 1'b1;
         wen_t_o       <= 1'b1;
         a_t_o         <= '0;
         d_t_o         <= '0;
         cmp_valid_q   <= 1'b0;
         cmp_addr_q    <= '0;
         cmp_elem_q    <= M0;
         busy_o        <= 1'b0;
         bist_o        <= 1'b0;
         done_o        <= 1'b0;
         fail_o        <= 1'b0;
         fail_addr_o   <= '0;
         fail_elem_o   <= 3'd0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         elem_q        <= elem_d;
         op_q          <= op_d;
         last_issued_q <= last_issued_d;
         port_elem_q   <= port_elem_d;
         csn_t_o       <= csn_d;
         wen_t_o       <= wen_d;
         a_t_o         <= a_d;
         d_t_o         <= d_d;
         cmp_valid_q   <= !csn_t_o && wen_t_o;
         cmp_addr_q    <= a_t_o;
         cmp_elem_q    <= port_elem_q;
         busy_o        <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         bist_o        <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         done_o        <= (state_d == ST_DONE);
         if (accept) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= 3'd0;
         end else if (mismatch && !fail_o) begin
            fail_o      <= 1'b1;
            fail_addr_o <= cmp_addr_q;
            fail_elem_o <= cmp_elem_q;
         end
      end
   end

endmodule
